// File: rtl/wb_ram_ctrl.sv
// Wishbone B3 slave bridging to a synchronous single-cycle-read RAM.
// Supports classic cycles plus constant/incrementing bursts with linear and wrap addressing.
module wb_ram_ctrl #(
    parameter int RAM_AW      = 15,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_din,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {IDLE, ACK, ERR} state_t;

    localparam logic [RAM_AW-1:0] ONE = RAM_AW'(1);

    state_t            state, state_nxt;
    logic [RAM_AW-1:0] adr_q, adr_nxt;
    logic [RAM_AW-1:0] word_adr;
    logic              req;
    logic              out_of_range;
    logic              burst;
    logic              ack;
    logic              err;
    logic              unused_ok;

    // Constant-address bursts repeat adr_q; incrementing bursts wrap inside a 4/8/16-word block.
    function automatic logic [RAM_AW-1:0] next_adr(input logic [RAM_AW-1:0] a,
                                                   input logic [2:0]        cti,
                                                   input logic [1:0]        bte);
        logic [RAM_AW-1:0] inc;
        logic [RAM_AW-1:0] mask;
        inc = a + ONE;
        case (bte)
            2'b01:   mask = RAM_AW'(3);
            2'b10:   mask = RAM_AW'(7);
            2'b11:   mask = RAM_AW'(15);
            default: mask = '1;
        endcase
        if (cti == 3'b001)
            return a;
        return (a & ~mask) | (inc & mask);
    endfunction

    assign word_adr     = wb_adr_i[RAM_AW+1:2];
    assign req          = wb_cyc_i & wb_stb_i;
    assign out_of_range = CHECK_RANGE && ((wb_adr_i >> (RAM_AW + 2)) != 32'h0);
    assign burst        = (wb_cti_i == 3'b010) || (wb_cti_i == 3'b001);
    assign unused_ok    = &{1'b0, wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            adr_q <= '0;
        end else begin
            state <= state_nxt;
            adr_q <= adr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        adr_nxt   = adr_q;
        ram_raddr = adr_q;
        ack       = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                // Present the bus address straight to the RAM so data is ready on the ack cycle.
                ram_raddr = word_adr;
                if (req) begin
                    if (out_of_range) begin
                        state_nxt = ERR;
                    end else begin
                        adr_nxt   = word_adr;
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                if (!wb_cyc_i) begin
                    state_nxt = IDLE;
                end else if (wb_stb_i) begin
                    ack = 1'b1;
                    if (burst) begin
                        adr_nxt   = next_adr(adr_q, wb_cti_i, wb_bte_i);
                        ram_raddr = adr_nxt;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            ERR: begin
                err       = req;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Responses are suppressed for the whole reset cycle, even if the FSM was mid-burst.
    assign wb_ack_o  = ack & ~rst;
    assign wb_err_o  = err & ~rst;
    assign wb_dat_o  = wb_ack_o ? ram_dout : 32'h0;
    assign ram_we    = (wb_ack_o & wb_we_i) ? wb_sel_i : 4'h0;
    assign ram_din   = wb_dat_i;
    assign ram_waddr = adr_q;

endmodule

// File: tb/tb_wb_ram_ctrl.sv
// Directed bench for wb_ram_ctrl: cycle-by-cycle vector table plus reset and range-error sequences.
module tb_wb_ram_ctrl;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [31:0]   adr, dat;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;

    logic          ack, err, ack2, err2;
    logic [31:0]   dat_o, dat_o2;
    logic [3:0]    ram_we, ram_we2;
    logic [31:0]   ram_din, ram_din2, ram_dout, ram_dout2;
    logic [AW-1:0] ram_waddr, ram_raddr, ram_waddr2, ram_raddr2;

    logic [31:0]   mem  [0:(1<<AW)-1];
    logic [31:0]   mem2 [0:(1<<AW)-1];

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    wb_ram_ctrl #(.RAM_AW(AW), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_ack_o(ack), .wb_err_o(err), .wb_dat_o(dat_o),
        .ram_we(ram_we), .ram_din(ram_din),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    wb_ram_ctrl #(.RAM_AW(AW), .CHECK_RANGE(1'b0)) dut2 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_ack_o(ack2), .wb_err_o(err2), .wb_dat_o(dat_o2),
        .ram_we(ram_we2), .ram_din(ram_din2),
        .ram_waddr(ram_waddr2), .ram_raddr(ram_raddr2), .ram_dout(ram_dout2)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b])  mem[ram_waddr][8*b +: 8]   <= ram_din[8*b +: 8];
            if (ram_we2[b]) mem2[ram_waddr2][8*b +: 8] <= ram_din2[8*b +: 8];
        end
        ram_dout  <= mem[ram_raddr];
        ram_dout2 <= mem2[ram_raddr2];
    end

    typedef struct {
        logic        cyc, stb, we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        e_ack, e_err;
        logic [3:0]  e_we;
        logic        chk_dat;
        logic [31:0] e_dat;
        int          e_ra;
        int          e_wa;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, s, w, input logic [31:0] a, d, input logic [3:0] sl,
                       input logic [2:0] ct, input logic [1:0] bt,
                       input logic ea, ee, input logic [3:0] ew,
                       input logic cd, input logic [31:0] ed, input int era, input int ewa);
        vec_t v;
        v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.dat = d; v.sel = sl;
        v.cti = ct; v.bte = bt; v.e_ack = ea; v.e_err = ee; v.e_we = ew;
        v.chk_dat = cd; v.e_dat = ed; v.e_ra = era; v.e_wa = ewa;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, c, s, w, input logic [31:0] a, d, input logic [3:0] sl,
                         input logic [2:0] ct, input logic [1:0] bt);
        @(posedge clk);
        #1;
        rst = r; cyc = c; stb = s; we = w; adr = a; dat = d; sel = sl; cti = ct; bte = bt;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ack"}, 32'(ack), 32'h0);
        chk({tag, " err"}, 32'(err), 32'h0);
        chk({tag, " we"},  32'(ram_we), 32'h0);
        chk({tag, " dat"}, dat_o, 32'h0);
    endtask

    localparam logic [2:0] C = 3'b000;
    localparam logic [2:0] L = 3'b010;
    localparam logic [2:0] E = 3'b111;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
        sel = '0; cti = '0; bte = '0;

        // classic write / read of word 4, then byte-lane write
        add(1,1,1,'h10,'hDEADBEEF,'hF,C,0, 0,0,'h0, 1,0,            4,-1);
        add(1,1,1,'h10,'hDEADBEEF,'hF,C,0, 1,0,'hF, 0,0,           -1, 4);
        add(0,0,0,'h00,0,'h0,C,0,          0,0,'h0, 1,0,           -1,-1);
        add(1,1,0,'h10,0,'hF,C,0,          0,0,'h0, 1,0,            4,-1);
        add(1,1,0,'h10,0,'hF,C,0,          1,0,'h0, 1,'hDEADBEEF,  -1,-1);
        add(1,1,1,'h10,'h00AA0000,'h4,C,0, 0,0,'h0, 1,0,            4,-1);
        add(1,1,1,'h10,'h00AA0000,'h4,C,0, 1,0,'h4, 0,0,           -1, 4);
        add(0,0,0,'h00,0,'h0,C,0,          0,0,'h0, 1,0,           -1,-1);
        add(1,1,0,'h10,0,'hF,C,0,          0,0,'h0, 1,0,            4,-1);
        add(1,1,0,'h10,0,'hF,C,0,          1,0,'h0, 1,'hDEAABEEF,  -1,-1);
        add(1,1,1,'h00,'h12345678,'hF,C,0, 0,0,'h0, 1,0,            0,-1);
        add(1,1,1,'h00,'h12345678,'hF,C,0, 1,0,'hF, 0,0,           -1, 0);
        // linear write burst words 8..11; bus address is junk during acks
        add(1,1,1,'h20,0,'hF,L,0,                0,0,'h0, 1,0,  8,-1);
        add(1,1,1,'hFFFFFFF0,'h11110008,'hF,L,0, 1,0,'hF, 0,0,  9, 8);
        add(1,1,1,'hFFFFFFF0,'h11110009,'hF,L,0, 1,0,'hF, 0,0, 10, 9);
        add(1,1,1,'hFFFFFFF0,'h1111000A,'hF,L,0, 1,0,'hF, 0,0, 11,10);
        add(1,1,1,'hFFFFFFF0,'h1111000B,'hF,E,0, 1,0,'hF, 0,0, -1,11);
        add(0,0,0,'h00,0,'h0,C,0,                0,0,'h0, 1,0, -1,-1);
        // wrap4 write burst words 4..7
        add(1,1,1,'h10,0,'hF,L,1,          0,0,'h0, 1,0,  4,-1);
        add(1,1,1,'h00,'h22220004,'hF,L,1, 1,0,'hF, 0,0,  5, 4);
        add(1,1,1,'h00,'h22220005,'hF,L,1, 1,0,'hF, 0,0,  6, 5);
        add(1,1,1,'h00,'h22220006,'hF,L,1, 1,0,'hF, 0,0,  7, 6);
        add(1,1,1,'h00,'h22220007,'hF,E,1, 1,0,'hF, 0,0, -1, 7);
        add(0,0,0,'h00,0,'h0,C,0,          0,0,'h0, 1,0, -1,-1);
        // linear read burst of 4 from 0x20, then a classic read proves IDLE
        add(1,1,0,'h20,0,'hF,L,0, 0,0,'h0, 1,0,            8,-1);
        add(1,1,0,'h20,0,'hF,L,0, 1,0,'h0, 1,'h11110008,   9,-1);
        add(1,1,0,'h20,0,'hF,L,0, 1,0,'h0, 1,'h11110009,  10,-1);
        add(1,1,0,'h20,0,'hF,L,0, 1,0,'h0, 1,'h1111000A,  11,-1);
        add(1,1,0,'h20,0,'hF,E,0, 1,0,'h0, 1,'h1111000B,  -1,-1);
        add(1,1,0,'h10,0,'hF,C,0, 0,0,'h0, 1,0,            4,-1);
        add(1,1,0,'h10,0,'hF,C,0, 1,0,'h0, 1,'h22220004,  -1,-1);
        // wrap4 read from word 6 with one wait state
        add(1,1,0,'h18,0,'hF,L,1, 0,0,'h0, 1,0,            6,-1);
        add(1,1,0,'h18,0,'hF,L,1, 1,0,'h0, 1,'h22220006,   7,-1);
        add(1,1,0,'h18,0,'hF,L,1, 1,0,'h0, 1,'h22220007,   4,-1);
        add(1,0,1,'h18,0,'hF,L,1, 0,0,'h0, 1,0,            4, 4);
        add(1,1,0,'h18,0,'hF,L,1, 1,0,'h0, 1,'h22220004,   5,-1);
        add(1,1,0,'h18,0,'hF,E,1, 1,0,'h0, 1,'h22220005,  -1,-1);
        // cyc dropped mid-burst
        add(1,1,0,'h20,0,'hF,L,0,                0,0,'h0, 1,0,            8,-1);
        add(1,1,0,'h20,0,'hF,L,0,                1,0,'h0, 1,'h11110008,   9,-1);
        add(0,1,1,'h20,'hFFFFFFFF,'hF,L,0,       0,0,'h0, 1,0,           -1,-1);
        add(1,1,0,'h10,0,'hF,C,0,                0,0,'h0, 1,0,            4,-1);
        add(1,1,0,'h10,0,'hF,C,0,                1,0,'h0, 1,'h22220004,  -1,-1);
        add(0,0,0,'h00,0,'h0,C,0,                0,0,'h0, 1,0,           -1,-1);

        // reset state, with bus activity held during reset
        drive(1,1,1,0,'h10,0,'hF,C,0);
        chk_quiet("rst0");
        drive(1,1,1,0,'h10,0,'hF,C,0);
        chk_quiet("rst1");
        chk("rst1 waddr", 32'(ram_waddr), 32'h0);
        drive(0,0,0,0,'h00,0,'h0,C,0);
        chk_quiet("rst+1");

        foreach (tbl[i]) begin
            drive(0, tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat,
                  tbl[i].sel, tbl[i].cti, tbl[i].bte);
            chk($sformatf("r%0d ack", i), 32'(ack), 32'(tbl[i].e_ack));
            chk($sformatf("r%0d err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("r%0d we", i),  32'(ram_we), 32'(tbl[i].e_we));
            if (tbl[i].chk_dat) chk($sformatf("r%0d dat", i), dat_o, tbl[i].e_dat);
            if (tbl[i].e_ra >= 0) chk($sformatf("r%0d raddr", i), 32'(ram_raddr), 32'(tbl[i].e_ra));
            if (tbl[i].e_wa >= 0) chk($sformatf("r%0d waddr", i), 32'(ram_waddr), 32'(tbl[i].e_wa));
        end

        // out-of-range read and write; the unchecked instance serves word 0 instead
        drive(0,1,1,0,'h00020000,0,'hF,C,0);
        chk("oor rd0 ack", 32'(ack), 32'h0);
        chk("oor rd0 err", 32'(err), 32'h0);
        chk("oor rd0 raddr2", 32'(ram_raddr2), 32'h0);
        drive(0,1,1,0,'h00020000,0,'hF,C,0);
        chk("oor rd1 err", 32'(err), 32'h1);
        chk("oor rd1 ack", 32'(ack), 32'h0);
        chk("oor rd1 we", 32'(ram_we), 32'h0);
        chk("oor rd1 dat", dat_o, 32'h0);
        chk("nochk rd1 ack", 32'(ack2), 32'h1);
        chk("nochk rd1 err", 32'(err2), 32'h0);
        chk("nochk rd1 dat", dat_o2, 32'h12345678);
        drive(0,0,0,0,'h0,0,'h0,C,0);
        chk_quiet("oor idle");
        drive(0,1,1,1,'h00020000,'hCAFEF00D,'hF,C,0);
        chk("oor wr0 err", 32'(err), 32'h0);
        drive(0,1,1,1,'h00020000,'hCAFEF00D,'hF,C,0);
        chk("oor wr1 err", 32'(err), 32'h1);
        chk("oor wr1 we", 32'(ram_we), 32'h0);
        chk("oor wr1 ack", 32'(ack), 32'h0);
        chk("nochk wr1 we", 32'(ram_we2), 32'hF);
        drive(0,0,0,0,'h0,0,'h0,C,0);
        chk_quiet("oor wr idle");

        // reset on the third beat of a linear read burst
        drive(0,1,1,0,'h20,0,'hF,L,0);
        chk("mb0 raddr", 32'(ram_raddr), 32'd8);
        drive(0,1,1,0,'h20,0,'hF,L,0);
        chk("mb1 dat", dat_o, 32'h11110008);
        drive(0,1,1,0,'h20,0,'hF,L,0);
        chk("mb2 dat", dat_o, 32'h11110009);
        drive(1,1,1,0,'h20,0,'hF,L,0);
        chk_quiet("mb3 rst");
        drive(0,1,1,0,'h18,0,'hF,C,0);
        chk_quiet("mb4");
        chk("mb4 waddr", 32'(ram_waddr), 32'h0);
        chk("mb4 raddr", 32'(ram_raddr), 32'd6);
        drive(0,1,1,0,'h18,0,'hF,C,0);
        chk("mb5 ack", 32'(ack), 32'h1);
        chk("mb5 dat", dat_o, 32'h22220006);
        drive(0,0,0,0,'h0,0,'h0,C,0);
        chk_quiet("mb6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/wb_ram_ctrl.md
WB_RAM_CTRL -- requirements
Module: wb_ram_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 15, meaning RAM word-address width.
REQ-002 SHALL have parameter CHECK_RANGE, default 1, meaning assert wb_err_o for addresses beyond RAM size.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone B3 cycle, strobe, write-enable.
REQ-006 SHALL have port wb_adr_i  input  32  byte address; word address = wb_adr_i[RAM_AW+1:2].
REQ-007 SHALL have ports wb_dat_i  input  32, and wb_sel_i  input  4  write data and byte lanes.
REQ-008 SHALL have ports wb_cti_i  input  3, and wb_bte_i  input  2  cycle type and burst type.
REQ-009 SHALL have ports wb_ack_o, wb_err_o  output  1 each, and wb_dat_o  output  32.
REQ-010 SHALL have ports ram_we  output  4, ram_din  output  32, ram_waddr and ram_raddr  output  RAM_AW each.
REQ-011 SHALL have port ram_dout  input  32  RAM read data, valid one clk after ram_raddr is presented.

Function
REQ-012 SHALL implement FSM states IDLE, ACK, ERR; internal registered word address adr_q.
REQ-013 In IDLE, ram_raddr SHALL equal the wb_adr_i word address combinationally.
REQ-014 IDLE with cyc&stb: if CHECK_RANGE=1 and wb_adr_i[31:RAM_AW+2]!=0 -> ERR; else adr_q<=word address, -> ACK.
REQ-015 In ACK, wb_ack_o SHALL equal wb_cyc_i&wb_stb_i (never asserted with cyc or stb low).
REQ-016 Read latency: ack asserted exactly one cycle after stb first sampled in IDLE; wb_dat_o=ram_dout during ack, 32'h0 otherwise.
REQ-017 Write: ram_we SHALL equal wb_sel_i when wb_ack_o&wb_we_i, else 4'h0; ram_din=wb_dat_i; ram_waddr=adr_q.
REQ-018 ACK with ack asserted and cti=3'b010 or 3'b001: stay ACK, adr_q<=next address; ram_raddr=next address that cycle so next data is ready (one ack per clk).
REQ-019 ACK with ack asserted and cti=3'b000 or 3'b111 (or any other value): -> IDLE; classic transfers therefore occupy two cycles.
REQ-020 ACK with cyc=1, stb=0 (burst wait state): hold state and adr_q, no ack, no write, ram_raddr=adr_q.
REQ-021 Next address: cti=001 -> adr_q; cti=010 with bte=00 -> adr_q+1 modulo 2^RAM_AW; bte=01/10/11 -> increment low 2/3/4 bits only, upper bits unchanged.
REQ-022 During ACK, wb_adr_i SHALL be ignored; address comes only from adr_q.
REQ-023 ERR: wb_err_o=wb_cyc_i&wb_stb_i for one cycle, ram_we=0, wb_ack_o=0, then -> IDLE.
REQ-024 wb_cyc_i low in any state: next state IDLE; no ack, err or write that cycle.
REQ-025 wb_ack_o and wb_err_o SHALL never be asserted in the same cycle.

Reset
REQ-026 rst=1 SHALL force state IDLE, adr_q=0 at next edge, taking priority over all bus activity, including mid-burst.
REQ-027 While in reset and the cycle after: wb_ack_o=0, wb_err_o=0, ram_we=0, wb_dat_o=0.

Verification
REQ-028 Classic write adr=0x10, dat=0xDEADBEEF, sel=4'hF, cti=000 -> one ack cycle 1 clk after stb, ram_we=4'hF, ram_waddr=4; then read adr=0x10 -> wb_dat_o=0xDEADBEEF with ack.
REQ-029 Byte write sel=4'b0100, dat=0x00AA0000 to word 4 -> readback 0xDEAABEEF.
REQ-030 Linear read burst of 4 from adr=0x20 (cti 010,010,010,111) -> acks on 4 consecutive cycles, ram_raddr 8,9,10,11; FSM IDLE after last.
REQ-031 Wrap4 burst bte=01 from word 6 -> addresses 6,7,4,5; stb dropped one cycle mid-burst -> no ack that cycle, burst resumes with correct data.
REQ-032 Read adr=0x0002_0000 with RAM_AW=15 -> wb_err_o one cycle, no ack, ram_we=0; CHECK_RANGE=0 -> normal ack at word 0.
REQ-033 rst asserted during 3rd beat of a burst -> no ack next cycle, state IDLE, adr_q=0; new classic read then completes normally.
